block_scheduler: RTL and testbench

Round-robin block scheduler that sits between the GPU top level and the compute cores. It replaces static per-core dispatch with a per-core state machine that sequences each core through reset, run and retire. Blocks are issued one per cycle to the next free core in rotation, and kernel completion is tracked. It drives the same core start, reset, block-id and thread-count controls the cores already consume.

---
 rtl/block_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_block_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_scheduler.sv
// block_scheduler: round-robin dispatch of kernel blocks onto NUM_CORES compute cores.
// Define BLOCK_SCHEDULER_WATCHDOG_EN to add per-core run watchdogs and the sticky error flag.
module block_scheduler #(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [7:0]                         thread_count,
    input  logic [NUM_CORES-1:0]               core_done,
    output logic [NUM_CORES-1:0]               core_start,
    output logic [NUM_CORES-1:0]               core_reset,
    output logic [7:0]                         core_block_id     [NUM_CORES],
    output logic [$clog2(THREADS_PER_BLOCK):0] core_thread_count [NUM_CORES],
    output logic                               busy,
    output logic                               done,
    output logic                               error
);
    localparam int unsigned LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int unsigned TC_W     = LOG2_TPB + 1;
    localparam int unsigned PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, PREP, DISPATCH, DONE} state_e;
    typedef enum logic [1:0] {C_IDLE, C_LOAD, C_RUN} core_state_e;

    state_e               state_q;
    core_state_e          cstate_q [NUM_CORES];
    logic [7:0]           tc_q;
    logic [8:0]           total_q;
    logic [8:0]           dispatched_q;
    logic [8:0]           blocks_done_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [NUM_CORES-1:0] start_q;
    logic [NUM_CORES-1:0] reset_q;
    logic [7:0]           block_id_q [NUM_CORES];
    logic [TC_W-1:0]      blk_tc_q   [NUM_CORES];
    logic                 busy_q;
    logic                 done_q;

    logic [8:0]           total_d;
    logic [8:0]           tot_eff;
    logic [8:0]           disp_eff;
    logic [8:0]           bdone_eff;
    logic [8:0]           rem_threads;
    logic [8:0]           ndone;
    logic [PTR_W-1:0]     ptr_eff;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     cand;
    logic [NUM_CORES-1:0] issue_vec;
    logic [NUM_CORES-1:0] leaving;
    logic [NUM_CORES-1:0] wd_expire;
    logic                 in_prep;
    logic                 can_issue;
    logic                 issue;
    logic                 all_idle;
    logic [TC_W-1:0]      issue_tc;

    // PREP already issues block 0: its counters and pointer are treated as cleared
    // so the first core loads on the PREP -> DISPATCH edge.
    always_comb begin
        in_prep   = (state_q == PREP);
        total_d   = ({1'b0, tc_q} + 9'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;
        tot_eff   = in_prep ? total_d : total_q;
        disp_eff  = in_prep ? '0 : dispatched_q;
        bdone_eff = in_prep ? '0 : blocks_done_q;
        ptr_eff   = in_prep ? '0 : ptr_q;
        can_issue = (in_prep || state_q == DISPATCH) && (disp_eff < tot_eff);

        issue_vec = '0;
        issue     = 1'b0;
        ptr_d     = ptr_eff;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cand = PTR_W'((32'(ptr_eff) + i) % NUM_CORES);
            if (can_issue && !issue && cstate_q[cand] == C_IDLE) begin
                issue           = 1'b1;
                issue_vec[cand] = 1'b1;
                ptr_d           = PTR_W'((32'(cand) + 1) % NUM_CORES);
            end
        end

        rem_threads = {1'b0, tc_q} - (disp_eff << LOG2_TPB);
        issue_tc    = (disp_eff == tot_eff - 9'd1) ? rem_threads[TC_W-1:0]
                                                   : TC_W'(THREADS_PER_BLOCK);

        leaving  = '0;
        all_idle = 1'b1;
        ndone    = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            leaving[c] = (cstate_q[c] == C_RUN) && (core_done[c] || wd_expire[c]);
            ndone      = ndone + 9'(leaving[c]);
            if (cstate_q[c] != C_IDLE) all_idle = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tc_q          <= '0;
            total_q       <= '0;
            dispatched_q  <= '0;
            blocks_done_q <= '0;
            ptr_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= '0;
            reset_q       <= '1;
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                cstate_q[c]   <= C_IDLE;
                block_id_q[c] <= '0;
                blk_tc_q[c]   <= TC_W'(THREADS_PER_BLOCK);
            end
        end else begin
            if (in_prep) total_q <= total_d;
            dispatched_q  <= disp_eff + 9'(issue);
            blocks_done_q <= bdone_eff + ndone;
            ptr_q         <= ptr_d;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= PREP;
                        tc_q    <= thread_count;
                        busy_q  <= 1'b1;
                    end
                end
                PREP: begin
                    if (total_d == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (blocks_done_q == total_q && all_idle) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                case (cstate_q[c])
                    C_IDLE: begin
                        if (issue_vec[c]) begin
                            cstate_q[c]   <= C_LOAD;
                            block_id_q[c] <= disp_eff[7:0];
                            blk_tc_q[c]   <= issue_tc;
                        end
                    end
                    C_LOAD: begin
                        cstate_q[c] <= C_RUN;
                        start_q[c]  <= 1'b1;
                        reset_q[c]  <= 1'b0;
                    end
                    C_RUN: begin
                        if (leaving[c]) begin
                            cstate_q[c] <= C_IDLE;
                            start_q[c]  <= 1'b0;
                            reset_q[c]  <= 1'b1;
                        end
                    end
                    default: cstate_q[c] <= C_IDLE;
                endcase
            end
        end
    end

`ifdef BLOCK_SCHEDULER_WATCHDOG_EN
    logic [15:0] wd_cnt_q [NUM_CORES];
    logic        error_q;

    always_comb begin
        wd_expire = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            wd_expire[c] = (cstate_q[c] == C_RUN) && (wd_cnt_q[c] == 16'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
            for (int unsigned c = 0; c < NUM_CORES; c++) wd_cnt_q[c] <= '0;
        end else begin
            if (state_q == IDLE && start) error_q <= 1'b0;
            else if (|(wd_expire & ~core_done)) error_q <= 1'b1;
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                if (cstate_q[c] == C_LOAD) wd_cnt_q[c] <= '0;
                else if (cstate_q[c] == C_RUN) wd_cnt_q[c] <= wd_cnt_q[c] + 16'd1;
            end
        end
    end

    assign error = error_q;
`else
    logic unused_timeout;
    assign wd_expire      = '0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign error          = 1'b0;
`endif

    assign core_start        = start_q;
    assign core_reset        = reset_q;
    assign core_block_id     = block_id_q;
    assign core_thread_count = blk_tc_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Scoreboard bench for block_scheduler: directed launches queue expected core_start
// rises and done rises; a negedge monitor pops and compares them.
module tb_block_scheduler;
    localparam int unsigned NC  = 2;
    localparam int unsigned TPB = 4;
    localparam int unsigned TCW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [7:0]     thread_count;
    logic [NC-1:0]  core_done;
    logic [NC-1:0]  core_start;
    logic [NC-1:0]  core_reset;
    logic [7:0]     core_block_id     [NC];
    logic [TCW-1:0] core_thread_count [NC];
    logic           busy;
    logic           done;
    logic           error;

    block_scheduler #(
        .NUM_CORES        (NC),
        .THREADS_PER_BLOCK(TPB),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .thread_count     (thread_count),
        .core_done        (core_done),
        .core_start       (core_start),
        .core_reset       (core_reset),
        .core_block_id    (core_block_id),
        .core_thread_count(core_thread_count),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cy;
        int core;
        int bid;
        int tc;
    } ev_t;

    ev_t exp_q[$];
    int  done_exp_q[$];
    int  errors = 0;
    int  checks = 0;

    function automatic void check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] tc, output int k);
        start        = 1'b1;
        thread_count = tc;
        k            = cyc + 1;
    endtask

    task automatic exp_start(input int cy, input int core, input int bid, input int tc);
        exp_q.push_back('{cy, core, bid, tc});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("done_timeout_outstanding", done_exp_q.size(), 0);
        done_exp_q.delete();
    endtask

    // Core model: asserts core_done for one cycle after dly[c] cycles of core_start.
    int            dly [NC];
    int            run_cnt [NC];
    logic [NC-1:0] hang;
    initial begin
        core_done = '0;
        for (int i = 0; i < NC; i++) run_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NC; c++) begin
                if (core_start[c]) run_cnt[c]++;
                else run_cnt[c] = 0;
                core_done[c] = core_start[c] && !hang[c] && (run_cnt[c] == dly[c]);
            end
        end
    end

    logic [NC-1:0] prev_start = '0;
    logic          prev_done  = 1'b0;
    initial begin
        ev_t e;
        int  dc;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (core_start[c] && !prev_start[c]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: core %0d rose at cycle %0d, required no start", c, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("start_core", c, e.core);
                        check("start_cycle", cyc, e.cy);
                        check("start_block_id", int'(core_block_id[c]), e.bid);
                        check("start_thread_count", int'(core_thread_count[c]), e.tc);
                    end
                end
            end
            if (done && !prev_done) begin
                if (done_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: rose at cycle %0d, required no done", cyc);
                end else begin
                    dc = done_exp_q.pop_front();
                    check("done_cycle", cyc, dc);
                end
            end
            prev_start = core_start;
            prev_done  = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int k2;
        reset        = 1'b1;
        start        = 1'b0;
        thread_count = '0;
        hang         = '0;
        dly[0]       = 5;
        dly[1]       = 5;
        tick(3);
        check("rst_core_reset", int'(core_reset), 3);
        check("rst_core_start", int'(core_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        for (int c = 0; c < NC; c++) begin
            check("rst_block_id", int'(core_block_id[c]), 0);
            check("rst_thread_count", int'(core_thread_count[c]), TPB);
        end
        reset = 1'b0;
        tick(1);

        // 8 threads: two full blocks; start drops mid-kernel.
        launch(8'd8, k);
        exp_start(k + 2, 0, 0, 4);
        exp_start(k + 3, 1, 1, 4);
        done_exp_q.push_back(k + 9);
        tick(1);
        check("busy_prep", int'(busy), 1);
        tick(3);
        start = 1'b0;
        wait_done(60);
        check("done_release", int'(done), 0);
        check("busy_after_done", int'(busy), 0);

        // 10 threads: partial last block; thread_count change after latch ignored.
        tick(1);
        launch(8'd10, k);
        exp_start(k + 2, 0, 0, 4);
        exp_start(k + 3, 1, 1, 4);
        exp_start(k + 9, 0, 2, 2);
        done_exp_q.push_back(k + 15);
        tick(1);
        thread_count = 8'd255;
        wait_done(60);
        check("done_hold", int'(done), 1);
        start = 1'b0;
        tick(1);
        check("done_clear", int'(done), 0);

        // zero threads: one-cycle busy, no core starts.
        tick(1);
        launch(8'd0, k);
        done_exp_q.push_back(k + 1);
        tick(1);
        check("busy_zero_prep", int'(busy), 1);
        tick(1);
        check("busy_zero_after", int'(busy), 0);
        start = 1'b0;
        wait_done(10);
        tick(2);

        // 18 threads: simultaneous completion at k+10 with two blocks left, pointer at core 1.
        dly[0] = 3;
        dly[1] = 7;
        launch(8'd18, k);
        exp_start(k + 2, 0, 0, 4);
        exp_start(k + 3, 1, 1, 4);
        exp_start(k + 7, 0, 2, 4);
        exp_start(k + 12, 1, 3, 4);
        exp_start(k + 13, 0, 4, 2);
        done_exp_q.push_back(k + 20);
        wait_done(80);
        start = 1'b0;
        tick(2);

        // reset mid-dispatch, then relaunch from block 0.
        dly[0] = 5;
        dly[1] = 5;
        launch(8'd8, k);
        exp_start(k + 2, 0, 0, 4);
        exp_start(k + 3, 1, 1, 4);
        tick(5);
        reset = 1'b1;
        start = 1'b0;
        tick(1);
        check("midrst_core_reset", int'(core_reset), 3);
        check("midrst_core_start", int'(core_start), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        reset = 1'b0;
        tick(1);
        launch(8'd4, k2);
        exp_start(k2 + 2, 0, 0, 4);
        done_exp_q.push_back(k2 + 8);
        wait_done(60);
        start = 1'b0;
        tick(2);

`ifdef BLOCK_SCHEDULER_WATCHDOG_EN
        // core 1 hangs: forced idle after 16 run cycles, error set, kernel still completes.
        hang[1] = 1'b1;
        launch(8'd8, k);
        exp_start(k + 2, 0, 0, 4);
        exp_start(k + 3, 1, 1, 4);
        done_exp_q.push_back(k + 20);
        wait_done(80);
        check("watchdog_error", int'(error), 1);
        start = 1'b0;
        tick(2);
`else
        check("error_tied_low", int'(error), 0);
`endif

        check("leftover_starts", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
